s2p_rx_align: RTL and testbench
===============================

# s2p_rx_align

Serial-to-parallel lane receiver with comma-based byte alignment; the receive end of the single-lane serial link fed by the lane serializer. It samples one bit per enabled clock, hunts for the COM symbol, declares lock after a run of aligned COMs, and delivers data bytes with a one-cycle valid strobe. It has one instance per lane; the four outputs feed the lane un-striping stage on the byte clock side.

## Interface
- COM, 8'hBC: comma/idle symbol; the transmitter sends it whenever its VALID is low.
- LOCK_COMS, 4: number of consecutive aligned COMs needed to reach LOCKED, range 2..15.
- MAX_RUN, 64: maximum number of consecutive data bytes allowed while LOCKED. Used only with `S2P_RX_RELOCK_EN`.
- IN_CLK_2MHz, in, 1: bit clock. All logic is on the rising edge.
- IN_RESET_RX, in, 1: synchronous, active-high reset. It overrides IN_ENB_RX.
- IN_ENB_RX, in, 1: bit enable. When low, all state and outputs hold.
- IN_SERIAL, in, 1: serial data, MSB first.
- OUT_LANE, out, 8: last received data byte.
- OUT_VALID, out, 1: one-cycle strobe marking a new data byte on OUT_LANE.
- OUT_IDLE, out, 1: one-cycle strobe marking a COM received while LOCKED.
- OUT_ALIGNED, out, 1: high while the state is LOCKED.

## Operation
- Shift register `sr <= {sr[6:0], IN_SERIAL}` on every enabled cycle.
- Bit counter `bit_cnt` (3 bits). A boundary cycle is one where `sr` holds a complete aligned byte. At each boundary `bit_cnt <= 0`; otherwise it increments. In SYNC and LOCKED, a boundary is the cycle with `bit_cnt == 7`.
- States:
  - HUNT: every enabled cycle, if `sr == COM`, that cycle is a boundary. Set `com_cnt <= 1` and go to SYNC. No other cycle is a boundary.
  - SYNC: at each boundary:
    - `sr == COM`: increment `com_cnt`. When the incremented value equals LOCK_COMS, go to LOCKED.
    - Otherwise: go to HUNT and set `com_cnt <= 0`.
  - LOCKED: at each boundary:
    - `sr == COM`: pulse OUT_IDLE and clear `run_cnt`.
    - Otherwise: `OUT_LANE <= sr`, pulse OUT_VALID, increment `run_cnt`.
- Once LOCKED, the block leaves that state only on reset, or on watchdog expiry when `S2P_RX_RELOCK_EN` is defined.
- In LOCKED, a data byte equal to COM is indistinguishable from idle. The transmitter guarantees this never happens.
- `sr` resets to 0, so a false COM match straight after reset is impossible.

## Timing
- Reset values: OUT_LANE = 0, OUT_VALID = 0, OUT_IDLE = 0, OUT_ALIGNED = 0, state = HUNT, `sr` = 0, `bit_cnt` = 0, `com_cnt` = 0, `run_cnt` = 0.
- Latency: OUT_LANE/OUT_VALID update on the edge that ends the boundary cycle. That is 1 cycle after the byte's LSB enters `sr`, and 2 enabled clocks after the LSB is presented on IN_SERIAL.
- OUT_LANE holds its value until the next data byte.
- OUT_VALID and OUT_IDLE are high for exactly one cycle per byte, spaced at least 8 enabled cycles apart. They are never high together.
- OUT_ALIGNED rises on the same edge as the HUNT/SYNC→LOCKED transition. It falls on the edge leaving LOCKED, or 1 cycle after reset is sampled.
- Lock time from first COM: LOCK_COMS × 8 bit times, plus the 1-cycle output register.
- ENB low on a would-be boundary cycle delays the boundary. No bit is lost or duplicated.
- Reset mid-byte: the next cycle is HUNT with all registers cleared. Any partial byte is discarded and no strobe is emitted.

## Configuration
- `S2P_RX_RELOCK_EN` defined:
  - In LOCKED, a data byte that would make `run_cnt` exceed MAX_RUN forces HUNT at that boundary.
  - That byte is not delivered: no OUT_VALID.
  - OUT_ALIGNED drops on the same edge, and `com_cnt` and `run_cnt` clear.
- Not defined:
  - No `run_cnt` register.
  - LOCKED is sticky until reset.

## Structure
- Shared package `p2s_s2p_pkg` holds:
  - COM default (8'hBC).
  - State encoding HUNT = 2'd0, SYNC = 2'd1, LOCKED = 2'd2.
  - Lane width constant (8), which is also used by the serializer.
- One sub-module, `s2p_rx_shift`, containing the shift register and bit counter. Ports:
  - In: clk, reset, enb, serial, realign.
  - Out: `sr[7:0]`, `boundary`.
  - `realign` forces `bit_cnt <= 0`.
- The FSM, counters and output registers live in the top.

## Test plan
- Reset, then ENB = 1 with 32 zero bits → all outputs stay 0 and state stays HUNT.
- 3-bit junk prefix, then 4× 0xBC, then bytes 0xA5, 0x3C → OUT_ALIGNED rises after the 4th COM. OUT_VALID pulses twice, with OUT_LANE = 0xA5 then 0x3C, 8 cycles apart.
- While LOCKED, send 0xBC, 0x12, 0xBC → OUT_IDLE, OUT_VALID (OUT_LANE = 0x12), OUT_IDLE. OUT_LANE holds 0x12 afterwards.
- Send 2× 0xBC then 0x55 (LOCK_COMS = 4) → return to HUNT, OUT_ALIGNED stays 0, no OUT_VALID.
- Hold ENB low for 5 cycles mid-byte while LOCKED, with IN_SERIAL toggling → the byte is still received correctly and its strobe is delayed by 5 cycles. Assert reset mid-byte → the next cycle has all outputs 0.
- With `S2P_RX_RELOCK_EN`, MAX_RUN = 4: after lock, send 5 data bytes → 4 OUT_VALID strobes, then OUT_ALIGNED falls on the 5th byte's boundary.

Source files
------------

// File: rtl/p2s_s2p_pkg.sv
// Shared definitions for the lane serializer and the serial-to-parallel receiver.
package p2s_s2p_pkg;

  localparam int unsigned LANE_W = 8;
  localparam logic [LANE_W-1:0] COM_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StSync   = 2'd1,
    StLocked = 2'd2
  } rx_state_e;

endpackage

// File: rtl/s2p_rx_shift.sv
// Receive shift register and byte-phase bit counter for s2p_rx_align.
module s2p_rx_shift
  import p2s_s2p_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic              serial,
  input  logic              realign,
  output logic [LANE_W-1:0] sr,
  output logic              boundary
);

  logic [LANE_W-1:0] sr_q;
  logic [2:0]        bit_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else if (enb) begin
      sr_q      <= {sr_q[LANE_W-2:0], serial};
      // Count wraps 7 -> 0 at every aligned boundary; realign restarts the byte phase.
      bit_cnt_q <= realign ? 3'd0 : bit_cnt_q + 3'd1;
    end
  end

  assign sr       = sr_q;
  assign boundary = (bit_cnt_q == 3'd7);

endmodule

// File: rtl/s2p_rx_align.sv
// Serial-to-parallel lane receiver with COM-based byte alignment and lock detection.
// Optional macro S2P_RX_RELOCK_EN: data-run watchdog that drops lock after MAX_RUN bytes.
module s2p_rx_align
  import p2s_s2p_pkg::*;
#(
  parameter logic [LANE_W-1:0] COM       = COM_DEFAULT,
  parameter int unsigned       LOCK_COMS = 4,
  parameter int unsigned       MAX_RUN   = 64
) (
  input  logic              IN_CLK_2MHz,
  input  logic              IN_RESET_RX,
  input  logic              IN_ENB_RX,
  input  logic              IN_SERIAL,
  output logic [LANE_W-1:0] OUT_LANE,
  output logic              OUT_VALID,
  output logic              OUT_IDLE,
  output logic              OUT_ALIGNED
);

  if (LOCK_COMS < 2 || LOCK_COMS > 15 || MAX_RUN < 1) begin : g_bad_params
    $error("s2p_rx_align: LOCK_COMS must be 2..15 and MAX_RUN at least 1");
  end

  rx_state_e         state_q, state_d;
  logic [3:0]        com_cnt_q, com_cnt_d;
  logic [3:0]        com_inc;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              valid_q, valid_d;
  logic              idle_q, idle_d;
  logic [LANE_W-1:0] sr;
  logic              boundary;
  logic              realign;

`ifdef S2P_RX_RELOCK_EN
  localparam int unsigned RunW = $clog2(MAX_RUN + 1);
  logic [RunW-1:0] run_cnt_q, run_cnt_d;
`endif

  s2p_rx_shift u_shift (
    .clk      (IN_CLK_2MHz),
    .reset    (IN_RESET_RX),
    .enb      (IN_ENB_RX),
    .serial   (IN_SERIAL),
    .realign  (realign),
    .sr       (sr),
    .boundary (boundary)
  );

  always_comb begin
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    lane_d    = lane_q;
    valid_d   = 1'b0;
    idle_d    = 1'b0;
    realign   = 1'b0;
    com_inc   = com_cnt_q + 4'd1;
`ifdef S2P_RX_RELOCK_EN
    run_cnt_d = run_cnt_q;
`endif
    if (IN_ENB_RX) begin
      unique case (state_q)
        StHunt: begin
          // Any bit position may start a byte while hunting.
          if (sr == COM) begin
            realign   = 1'b1;
            com_cnt_d = 4'd1;
            state_d   = StSync;
          end
        end
        StSync: begin
          if (boundary) begin
            if (sr == COM) begin
              com_cnt_d = com_inc;
              if (com_inc == 4'(LOCK_COMS)) begin
                state_d = StLocked;
              end
            end else begin
              com_cnt_d = 4'd0;
              state_d   = StHunt;
            end
          end
        end
        StLocked: begin
          if (boundary) begin
            if (sr == COM) begin
              idle_d = 1'b1;
`ifdef S2P_RX_RELOCK_EN
              run_cnt_d = '0;
`endif
            end else begin
`ifdef S2P_RX_RELOCK_EN
              if (run_cnt_q == RunW'(MAX_RUN)) begin
                // Run too long for a live link: treat as lost alignment, drop the byte.
                state_d   = StHunt;
                com_cnt_d = 4'd0;
                run_cnt_d = '0;
              end else begin
                lane_d    = sr;
                valid_d   = 1'b1;
                run_cnt_d = run_cnt_q + 1'b1;
              end
`else
              lane_d  = sr;
              valid_d = 1'b1;
`endif
            end
          end
        end
        default: begin
          state_d   = StHunt;
          com_cnt_d = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge IN_CLK_2MHz) begin
    if (IN_RESET_RX) begin
      state_q   <= StHunt;
      com_cnt_q <= '0;
      lane_q    <= '0;
      valid_q   <= 1'b0;
      idle_q    <= 1'b0;
`ifdef S2P_RX_RELOCK_EN
      run_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      com_cnt_q <= com_cnt_d;
      lane_q    <= lane_d;
      valid_q   <= valid_d;
      idle_q    <= idle_d;
`ifdef S2P_RX_RELOCK_EN
      run_cnt_q <= run_cnt_d;
`endif
    end
  end

  assign OUT_LANE    = lane_q;
  assign OUT_VALID   = valid_q;
  assign OUT_IDLE    = idle_q;
  assign OUT_ALIGNED = (state_q == StLocked);

endmodule

// File: tb/tb_s2p_rx_align.sv
// Bench for s2p_rx_align: bit-history model checked every cycle plus directed literal checks.
`timescale 1ns / 1ps
module tb_s2p_rx_align;

  localparam logic [7:0] COM       = 8'hBC;
  localparam int         LOCK_COMS = 4;
`ifdef S2P_RX_RELOCK_EN
  localparam int         MAX_RUN   = 4;
  localparam bit         RELOCK    = 1'b1;
`else
  localparam int         MAX_RUN   = 64;
  localparam bit         RELOCK    = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       enb;
  logic       serial;
  logic [7:0] lane;
  logic       valid;
  logic       idle;
  logic       aligned;

  s2p_rx_align #(
    .COM       (COM),
    .LOCK_COMS (LOCK_COMS),
    .MAX_RUN   (MAX_RUN)
  ) dut (
    .IN_CLK_2MHz (clk),
    .IN_RESET_RX (rst),
    .IN_ENB_RX   (enb),
    .IN_SERIAL   (serial),
    .OUT_LANE    (lane),
    .OUT_VALID   (valid),
    .OUT_IDLE    (idle),
    .OUT_ALIGNED (aligned)
  );

  initial begin
    clk = 1'b0;
    forever #250 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: every accepted bit is kept; a byte boundary is 8 bits after the previous one
  // once aligned, or wherever the last 8 bits spell COM while hunting.
  bit         hist[$];
  int         bpos;
  int         m_state;  // 0 hunting, 1 counting COMs, 2 locked
  int         m_coms;
  int         m_run;
  int         cyc = 0;
  logic [7:0] exp_lane;
  bit         exp_valid, exp_idle, exp_aligned;
  bit         model_on = 1'b0;

  initial begin : model
    logic [7:0] last8;
    int         since;
    int         idx;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        hist.delete();
        bpos        = 0;
        m_state     = 0;
        m_coms      = 0;
        m_run       = 0;
        exp_lane    = 8'h00;
        exp_valid   = 1'b0;
        exp_idle    = 1'b0;
        exp_aligned = 1'b0;
        model_on    = 1'b1;
      end else begin
        exp_valid = 1'b0;
        exp_idle  = 1'b0;
        if (enb) begin
          last8 = 8'h00;
          for (int i = 0; i < 8; i++) begin
            idx   = hist.size() - 8 + i;
            last8 = {last8[6:0], (idx >= 0) ? hist[idx] : 1'b0};
          end
          since = hist.size() - bpos;
          if (m_state == 0) begin
            if (last8 == COM) begin
              bpos    = hist.size();
              m_coms  = 1;
              m_state = 1;
            end
          end else if (since == 8) begin
            bpos = hist.size();
            if (m_state == 1) begin
              if (last8 == COM) begin
                m_coms++;
                if (m_coms == LOCK_COMS) m_state = 2;
              end else begin
                m_coms  = 0;
                m_state = 0;
              end
            end else if (last8 == COM) begin
              exp_idle = 1'b1;
              m_run    = 0;
            end else if (RELOCK && m_run == MAX_RUN) begin
              m_state = 0;
              m_coms  = 0;
              m_run   = 0;
            end else begin
              exp_lane  = last8;
              exp_valid = 1'b1;
              m_run++;
            end
          end
          hist.push_back(serial);
        end
        exp_aligned = (m_state == 2);
      end
    end
  end

  logic [7:0] valid_log[$];
  int         valid_cyc[$];
  int         idle_cyc[$];

  initial begin : compare
    forever begin
      @(negedge clk);
      if (model_on) begin
        check("lane", {24'd0, lane}, {24'd0, exp_lane});
        check("valid", {31'd0, valid}, {31'd0, exp_valid});
        check("idle", {31'd0, idle}, {31'd0, exp_idle});
        check("aligned", {31'd0, aligned}, {31'd0, exp_aligned});
        if (valid) begin
          valid_log.push_back(lane);
          valid_cyc.push_back(cyc);
        end
        if (idle) idle_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick(input logic b, input logic e);
    serial = b;
    enb    = e;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) tick(b[i], 1'b1);
  endtask

  initial begin : stim
    rst    = 1'b1;
    enb    = 1'b0;
    serial = 1'b0;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    rst = 1'b0;

    // Zeros never look like COM.
    repeat (32) tick(1'b0, 1'b1);
    check("A_aligned", {31'd0, aligned}, 32'd0);
    check("A_nvalid", valid_log.size(), 32'd0);
    check("A_nidle", idle_cyc.size(), 32'd0);

    // Junk prefix, lock, two data bytes.
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    repeat (4) send_byte(COM);
    check("B_not_yet_locked", {31'd0, aligned}, 32'd0);
    send_byte(8'hA5);
    check("B_locked", {31'd0, aligned}, 32'd1);
    send_byte(8'h3C);
    send_byte(COM);
    check("B_nvalid", valid_log.size(), 32'd2);
    check("B_byte0", {24'd0, valid_log[0]}, 32'h0000_00A5);
    check("B_byte1", {24'd0, valid_log[1]}, 32'h0000_003C);
    check("B_spacing", valid_cyc[1] - valid_cyc[0], 32'd8);
    check("B_nidle", idle_cyc.size(), 32'd0);

    // Idle, data, idle while locked.
    send_byte(COM);
    send_byte(8'h12);
    send_byte(COM);
    send_byte(COM);
    check("C_nvalid", valid_log.size(), 32'd3);
    check("C_byte", {24'd0, valid_log[2]}, 32'h0000_0012);
    check("C_nidle", idle_cyc.size(), 32'd3);
    check("C_lane_hold", {24'd0, lane}, 32'h0000_0012);

    // 0x5A with a 5-cycle enable gap after its third bit, serial toggling meanwhile.
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    send_byte(COM);
    check("D_nvalid", valid_log.size(), 32'd4);
    check("D_byte", {24'd0, valid_log[3]}, 32'h0000_005A);
    check("D_delay", valid_cyc[3] - idle_cyc[3], 32'd13);

    // Reset in the middle of a byte.
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    rst = 1'b1;
    tick(1'b1, 1'b1);
    rst = 1'b0;
    check("E_outputs_cleared", {21'd0, lane, valid, idle, aligned}, 32'd0);
    repeat (8) tick(1'b0, 1'b1);
    check("E_nvalid", valid_log.size(), 32'd4);

    // Too few COMs before a data byte: back to hunting.
    send_byte(COM);
    send_byte(COM);
    send_byte(8'h55);
    repeat (8) tick(1'b0, 1'b1);
    check("F_aligned", {31'd0, aligned}, 32'd0);
    check("F_nvalid", valid_log.size(), 32'd4);
    check("F_nidle", idle_cyc.size(), 32'd5);

    // Long data run after lock.
    rst = 1'b1;
    tick(1'b0, 1'b1);
    rst = 1'b0;
    repeat (4) send_byte(COM);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    tick(1'b0, 1'b1);
    check("G_aligned", {31'd0, aligned}, RELOCK ? 32'd0 : 32'd1);
    repeat (7) tick(1'b0, 1'b1);
    check("G_nvalid", valid_log.size(), RELOCK ? 32'd8 : 32'd9);
    check("G_last_byte", {24'd0, valid_log[valid_log.size() - 1]},
          RELOCK ? 32'h0000_0044 : 32'h0000_0055);

    repeat (2) tick(1'b0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
